// File: rtl/ifetch_ctrl_if.sv
// Fetch controller bus: PC register, instruction memory and decode handshakes.
// master = fetch controller side, slave = PC register / memory / decode side.
interface ifetch_ctrl_if;
  logic [31:0] pc_in;
  logic        pc_ena;
  logic [31:0] pc_next;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  modport master (
    input  pc_in, redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
    output pc_ena, pc_next, imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_fault
  );

  modport slave (
    output pc_in, redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
    input  pc_ena, pc_next, imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_fault
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: one fetch per REQ/HOLD pair, inst_valid one edge after ack.
// Memory waits hold the request; decode backpressure holds the instruction in HOLD.
module ifetch_ctrl #(
  parameter logic [31:0] PC_STEP    = 32'd4,
  parameter logic [31:0] RESET_INST = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  ifetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fetch_fault_q, fetch_fault_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      imem_addr_q   <= 32'd0;
      inst_q        <= RESET_INST;
      inst_pc_q     <= 32'd0;
      inst_valid_q  <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_addr_q   <= imem_addr_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      inst_valid_q  <= inst_valid_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    inst_valid_d  = inst_valid_q;
    fetch_fault_d = fetch_fault_q;
    // Address tracks the PC register whenever no request is in flight.
    if (state_q == IDLE || state_q == HOLD) begin
      imem_addr_d = bus.pc_in;
    end else begin
      imem_addr_d = imem_addr_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.redirect) begin
          fetch_fault_d = 1'b0;
        end else if (bus.pc_in[1:0] != 2'b00) begin
          fetch_fault_d = 1'b1;
        end else if (!fetch_fault_q) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          if (bus.redirect) begin
            state_d = IDLE;
          end else begin
            inst_d       = bus.imem_rdata;
            inst_pc_d    = imem_addr_q;
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (bus.redirect) begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        // Redirect wins over decode acceptance: the held instruction is stale.
        if (bus.redirect) begin
          inst_valid_d = 1'b0;
          state_d      = IDLE;
        end else if (bus.inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
      end
      DRAIN: begin
        if (bus.imem_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.imem_req    = (state_q == REQ) || (state_q == DRAIN);
  assign bus.imem_addr   = imem_addr_q;
  assign bus.pc_ena      = !rst && (bus.redirect || (state_q == REQ && bus.imem_ack));
  assign bus.pc_next     = bus.redirect ? bus.redirect_pc : (imem_addr_q + PC_STEP);
  assign bus.inst_valid  = inst_valid_q;
  assign bus.inst        = inst_q;
  assign bus.inst_pc     = inst_pc_q;
  assign bus.fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a PC register and a wait-state memory model.
module tb_ifetch_ctrl;
  logic clk;
  logic rst;
  int   passed;
  int   failed;
  int   total;
  int   mem_wait;
  int   wcnt;
  logic [31:0] pc_reg;

  localparam logic [31:0] RST_INST = 32'hDEAD_BEEF;

  ifetch_ctrl_if bus ();

  ifetch_ctrl #(.PC_STEP(32'd4), .RESET_INST(RST_INST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) pc_reg <= 32'd0;
    else if (bus.pc_ena) pc_reg <= bus.pc_next;
  end
  assign bus.pc_in = pc_reg;

  // Memory acks once the request has been up for mem_wait extra cycles.
  always @(posedge clk) begin
    if (rst || !bus.imem_req || bus.imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end
  assign bus.imem_ack   = bus.imem_req && (wcnt == mem_wait);
  assign bus.imem_rdata = 32'h1000_0000 + bus.imem_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    passed = 0; failed = 0; total = 0;
    rst = 1'b1; mem_wait = 0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'd0; bus.inst_ready = 1'b1;
    tick(); tick();
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);
    chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst, RST_INST);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h44; #1;
    chk("rst_pc_ena_forced", {31'd0, bus.pc_ena}, 32'd0);
    bus.redirect = 1'b0;
    rst = 1'b0; #1;
    chk("idle_req", {31'd0, bus.imem_req}, 32'd0);
    chk("idle_pc_ena", {31'd0, bus.pc_ena}, 32'd0);
    tick();

    // Sequential zero-wait fetch: REQ, HOLD alternating.
    for (int k = 0; k < 4; k++) begin
      chk("seq_req", {31'd0, bus.imem_req}, 32'd1);
      chk("seq_addr", bus.imem_addr, 32'(4 * k));
      chk("seq_valid_low", {31'd0, bus.inst_valid}, 32'd0);
      chk("seq_pc_ena", {31'd0, bus.pc_ena}, 32'd1);
      chk("seq_pc_next", bus.pc_next, 32'(4 * k + 4));
      tick();
      chk("seq_valid", {31'd0, bus.inst_valid}, 32'd1);
      chk("seq_inst_pc", bus.inst_pc, 32'(4 * k));
      chk("seq_inst", bus.inst, 32'h1000_0000 + 32'(4 * k));
      chk("seq_hold_pc_ena", {31'd0, bus.pc_ena}, 32'd0);
      chk("seq_hold_req", {31'd0, bus.imem_req}, 32'd0);
      if (k == 3) mem_wait = 3;
      tick();
    end

    // Wait states on the fetch at 0x10.
    for (int i = 0; i < 3; i++) begin
      chk("ws_req", {31'd0, bus.imem_req}, 32'd1);
      chk("ws_addr", bus.imem_addr, 32'h10);
      chk("ws_pc_ena", {31'd0, bus.pc_ena}, 32'd0);
      chk("ws_valid", {31'd0, bus.inst_valid}, 32'd0);
      tick();
    end
    chk("ws_ack_pc_ena", {31'd0, bus.pc_ena}, 32'd1);
    chk("ws_ack_pc_next", bus.pc_next, 32'h14);
    bus.inst_ready = 1'b0;
    tick();

    // Decode backpressure for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", {31'd0, bus.inst_valid}, 32'd1);
      chk("bp_inst", bus.inst, 32'h1000_0010);
      chk("bp_inst_pc", bus.inst_pc, 32'h10);
      chk("bp_req", {31'd0, bus.imem_req}, 32'd0);
      chk("bp_pc_once", pc_reg, 32'h14);
      tick();
    end
    chk("bp_still_valid", {31'd0, bus.inst_valid}, 32'd1);

    // Redirect in HOLD with inst_ready high: instruction dropped.
    bus.inst_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h8; mem_wait = 2; #1;
    chk("hold_rd_pc_ena", {31'd0, bus.pc_ena}, 32'd1);
    chk("hold_rd_pc_next", bus.pc_next, 32'h8);
    tick(); bus.redirect = 1'b0; #1;
    chk("hold_rd_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("hold_rd_req", {31'd0, bus.imem_req}, 32'd0);
    tick();

    // Redirect while the request to 8 is pending, then a second redirect in DRAIN.
    chk("rq_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rq_addr", bus.imem_addr, 32'h8);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h100; #1;
    chk("rq_rd_pc_ena", {31'd0, bus.pc_ena}, 32'd1);
    chk("rq_rd_pc_next", bus.pc_next, 32'h100);
    tick(); bus.redirect = 1'b0; #1;
    chk("drain_req", {31'd0, bus.imem_req}, 32'd1);
    chk("drain_addr", bus.imem_addr, 32'h8);
    chk("drain_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("drain_pc", pc_reg, 32'h100);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h180; #1;
    chk("drain_rd_pc_ena", {31'd0, bus.pc_ena}, 32'd1);
    tick(); bus.redirect = 1'b0; #1;
    chk("drain_ack_req", {31'd0, bus.imem_req}, 32'd1);
    chk("drain_ack_pc_ena", {31'd0, bus.pc_ena}, 32'd0);
    chk("drain_pc2", pc_reg, 32'h180);
    tick();
    chk("drain_idle_req", {31'd0, bus.imem_req}, 32'd0);
    chk("drain_idle_valid", {31'd0, bus.inst_valid}, 32'd0);
    mem_wait = 0;
    tick();
    chk("after_rd_addr", bus.imem_addr, 32'h180);
    chk("after_rd_pc_next", bus.pc_next, 32'h184);
    tick();
    chk("after_rd_inst_pc", bus.inst_pc, 32'h180);
    chk("after_rd_inst", bus.inst, 32'h1000_0180);
    tick();

    // Redirect coinciding with ack in REQ.
    bus.redirect = 1'b1; bus.redirect_pc = 32'h300; #1;
    chk("sim_addr", bus.imem_addr, 32'h184);
    chk("sim_pc_next", bus.pc_next, 32'h300);
    tick(); bus.redirect = 1'b0; #1;
    chk("sim_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("sim_req", {31'd0, bus.imem_req}, 32'd0);
    chk("sim_pc", pc_reg, 32'h300);
    tick();
    chk("sim_next_addr", bus.imem_addr, 32'h300);
    tick();
    chk("sim_inst_pc", bus.inst_pc, 32'h300);

    // Misaligned redirect target, then recovery.
    bus.redirect = 1'b1; bus.redirect_pc = 32'h102; #1;
    tick(); bus.redirect = 1'b0; #1;
    chk("mis_fault_pre", {31'd0, bus.fetch_fault}, 32'd0);
    tick();
    chk("mis_fault", {31'd0, bus.fetch_fault}, 32'd1);
    chk("mis_req", {31'd0, bus.imem_req}, 32'd0);
    tick();
    chk("mis_fault_sticky", {31'd0, bus.fetch_fault}, 32'd1);
    chk("mis_req2", {31'd0, bus.imem_req}, 32'd0);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h200; #1;
    chk("mis_rd_pc_ena", {31'd0, bus.pc_ena}, 32'd1);
    tick(); bus.redirect = 1'b0; #1;
    chk("mis_cleared", {31'd0, bus.fetch_fault}, 32'd0);
    tick();
    chk("mis_resume_req", {31'd0, bus.imem_req}, 32'd1);
    chk("mis_resume_addr", bus.imem_addr, 32'h200);
    tick();
    chk("mis_resume_inst", bus.inst, 32'h1000_0200);

    // PC wrap at the top of the address space.
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; #1;
    tick(); bus.redirect = 1'b0; #1;
    tick();
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc_next", bus.pc_next, 32'h0);
    tick();
    chk("wrap_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst", bus.inst, 32'h0FFF_FFFC);
    chk("wrap_pc", pc_reg, 32'h0);

    // Reset while a request to 0x40 is pending.
    bus.redirect = 1'b1; bus.redirect_pc = 32'h40; mem_wait = 5; #1;
    tick(); bus.redirect = 1'b0; #1;
    tick();
    chk("mr_req", {31'd0, bus.imem_req}, 32'd1);
    chk("mr_addr", bus.imem_addr, 32'h40);
    tick();
    rst = 1'b1; bus.redirect = 1'b1; #1;
    chk("mr_pc_ena_forced", {31'd0, bus.pc_ena}, 32'd0);
    tick(); bus.redirect = 1'b0; #1;
    chk("mr_req0", {31'd0, bus.imem_req}, 32'd0);
    chk("mr_addr0", bus.imem_addr, 32'd0);
    chk("mr_valid0", {31'd0, bus.inst_valid}, 32'd0);
    chk("mr_inst0", bus.inst, RST_INST);
    chk("mr_inst_pc0", bus.inst_pc, 32'd0);
    chk("mr_fault0", {31'd0, bus.fetch_fault}, 32'd0);
    mem_wait = 0; rst = 1'b0; #1;
    tick();
    chk("mr_first_req", {31'd0, bus.imem_req}, 32'd1);
    chk("mr_first_addr", bus.imem_addr, 32'd0);
    chk("mr_first_pc_ena", {31'd0, bus.pc_ena}, 32'd1);
    tick();
    chk("mr_first_inst_pc", bus.inst_pc, 32'd0);
    chk("mr_first_inst", bus.inst, 32'h1000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller on the read side of the PC register. Each cycle it reads the current PC from the PC register, issues a word read to instruction memory over a req/ack handshake, and presents the returned instruction to decode over a valid/ready handshake. It also drives the PC register's enable and next-value inputs, so the PC advances only when a fetch completes or a redirect arrives.

## Interface
Parameters:
- `PC_STEP`, default 32'd4: increment applied to the PC after each completed fetch.
- `RESET_INST`, default 32'h0000_0000: value of `inst` during reset.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `pc_in`  in  32: current PC, taken from the PC register output.
- `pc_ena`  out  1: PC register enable; the PC register loads `pc_next` on the edge where this is high.
- `pc_next`  out  32: next PC value, driven to the PC register data input.
- `redirect`  in  1: branch/jump request, one-cycle pulse.
- `redirect_pc`  in  32: redirect target, valid while `redirect` is high.
- `imem_req`  out  1: instruction memory read request.
- `imem_addr`  out  32: instruction memory read address.
- `imem_ack`  in  1: read data valid; completes the request.
- `imem_rdata`  in  32: read data.
- `inst_valid`  out  1: `inst` and `inst_pc` hold a valid instruction.
- `inst_ready`  in  1: decode accepts the instruction.
- `inst`  out  32: fetched instruction.
- `inst_pc`  out  32: address the instruction was fetched from.
- `fetch_fault`  out  1: sticky flag for a misaligned PC.

## Operation
- States:
  - IDLE: PC settled, no request outstanding.
  - REQ: request outstanding.
  - HOLD: instruction presented to decode.
  - DRAIN: request outstanding, result to be discarded.
- `imem_addr` is a register.
  - It captures `pc_in` on every edge where the state is IDLE or HOLD.
  - It stays frozen while the state is REQ or DRAIN.
- `imem_req` = (state is REQ or DRAIN).
  - Once asserted, it stays high until `imem_ack`. A request is never withdrawn.
- `pc_ena` = `redirect` OR (state is REQ AND `imem_ack`).
- `pc_next` = `redirect` ? `redirect_pc` : `imem_addr` + `PC_STEP`.
  - The addition is modulo 2^32; the value wraps to 0 past 32'hFFFF_FFFC.
- IDLE:
  - If `redirect` is high: stay in IDLE and clear `fetch_fault`.
  - Else if `pc_in[1:0]` != 0: set `fetch_fault` and stay in IDLE, issuing no request.
  - Else if `fetch_fault` is clear: go to REQ.
- REQ:
  - `imem_ack` without `redirect`: load `inst` = `imem_rdata` and `inst_pc` = `imem_addr`; set `inst_valid`; go to HOLD.
  - `imem_ack` with `redirect`: discard the data and go to IDLE.
  - `redirect` without `imem_ack`: go to DRAIN. `pc_ena` loads `redirect_pc` on this edge.
- HOLD:
  - `redirect`: clear `inst_valid` and go to IDLE. `redirect` has priority over `inst_ready`; the instruction is dropped.
  - `inst_ready` with no `redirect`: clear `inst_valid` and go to REQ.
- DRAIN:
  - On `imem_ack`: discard the data and go to IDLE.
  - A further `redirect` during DRAIN updates the PC only; the state stays DRAIN until `imem_ack`.
- `inst_valid` is high only in HOLD. `inst` and `inst_pc` stay stable throughout HOLD.

## Timing
- Reset values:
  - State: IDLE.
  - `imem_req` = 0, `imem_addr` = 0.
  - `inst_valid` = 0, `inst` = `RESET_INST`, `inst_pc` = 0.
  - `fetch_fault` = 0.
  - `pc_ena` is forced to 0 while `rst` is high.
- `rst` asserted in any state, including REQ or DRAIN, returns the block to IDLE. Memory must also be reset by the same `rst`.
- The first request is issued 1 cycle after reset deasserts (IDLE, then REQ).
- With ack in the first REQ cycle, `inst_valid` rises on the next edge.
- Steady-state throughput with zero-wait memory and `inst_ready` tied high is 1 instruction per 2 cycles (REQ, HOLD, REQ, ...).
- A redirect costs at least 1 IDLE bubble, plus any DRAIN cycles.

## Test plan
- Sequential fetch:
  - Stimulus: reset with PC register = 0; memory with zero wait returns 32'h1000_0000 + addr; `inst_ready` = 1.
  - Required: `inst_pc` sequence 0, 4, 8, C with matching `inst`; `pc_ena` pulses once per fetch; `inst_valid` is never high on back-to-back cycles.
- Wait states and backpressure:
  - Stimulus: memory ack delayed 3 cycles; `inst_ready` low for 4 cycles.
  - Required: `imem_req` and `imem_addr` stay stable until ack; `inst` stays stable and `inst_valid` stays high until `inst_ready`; the PC advances exactly once.
- Redirect during REQ:
  - Stimulus: `redirect` to 32'h0000_0100 while a request to 8 is pending; ack arrives 2 cycles later.
  - Required: the data for 8 never appears; the next `inst_pc` is 32'h100.
- Redirect in HOLD with `inst_ready` high in the same cycle:
  - Required: the instruction is dropped and the next fetch address is `redirect_pc`.
  - Simultaneous `redirect` and ack in REQ: the data is discarded and the state goes to IDLE.
- Misaligned PC:
  - Stimulus: `redirect_pc` = 32'h0000_0102.
  - Required: `fetch_fault` = 1 and no `imem_req`; a later redirect to 32'h200 clears the fault and fetch resumes at 32'h200.
- Wrap and mid-op reset:
  - Stimulus: PC 32'hFFFF_FFFC; then assert `rst` during a pending request.
  - Required: `pc_next` = 0 after the fetch at 32'hFFFF_FFFC; reset returns all outputs to their reset values on the next edge.
